// File: rtl/fir_mac_sequencer.sv
// Decimating FIR sequencer: keeps a circular sample delay line and streams
// NTAPS (sample, coefficient) pairs per output into a first/last-tagged MAC.
module fir_mac_sequencer #(
  parameter int NTAPS = 64,
  parameter int AW    = 7,
  parameter int CAW   = 6,
  parameter int DECIM = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [17:0]    sin,
  input  logic           sin_valid,
  output logic [CAW-1:0] coef_addr,
  input  logic [27:0]    coef_data,
  output logic [17:0]    mac_din,
  output logic [27:0]    mac_cin,
  output logic           mac_first,
  output logic           mac_last,
  output logic           busy,
  output logic           ovr
);
  localparam int DEPTH = 2**AW;
  localparam int DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [CAW-1:0] LAST_TAP = CAW'(NTAPS - 1);
  localparam logic [DCW-1:0] LAST_DEC = DCW'(DECIM - 1);
  localparam logic [AW-1:0]  LAST_CLR = AW'(DEPTH - 1);

  logic [1:0]     state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  clr_cnt_q, clr_cnt_d;
  logic [DCW-1:0] dec_cnt_q, dec_cnt_d;
  logic [CAW-1:0] tap_q, tap_d;
  logic [AW-1:0]  base_q, base_d;
  logic           ovr_q, ovr_d;
  logic [17:0]    mac_din_q;
  logic           mac_first_q, mac_last_q;

  logic [17:0]    mem [DEPTH];

  logic           in_run, accept, trigger, last_tap, start;
  logic [AW-1:0]  rd_addr;

  assign in_run   = (state_q == S_RUN);
  assign accept   = sin_valid && (state_q != S_CLEAR);
  assign trigger  = accept && (dec_cnt_q == LAST_DEC);
  assign last_tap = in_run && (tap_q == LAST_TAP);
  // A trigger landing on the final tap chains straight into the next run.
  assign start    = trigger && ((state_q == S_IDLE) || last_tap);
  assign rd_addr  = base_q - AW'(tap_q);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    clr_cnt_d = clr_cnt_q;
    dec_cnt_d = dec_cnt_q;
    tap_d     = tap_q;
    base_d    = base_q;
    ovr_d     = ovr_q;

    case (state_q)
      S_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == LAST_CLR) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          tap_d   = '0;
          base_d  = wr_ptr_q;
        end
      end
      S_RUN: begin
        if (last_tap) begin
          tap_d = '0;
          if (start) base_d = wr_ptr_q;
          else       state_d = S_IDLE;
        end else begin
          tap_d = tap_q + CAW'(1);
        end
      end
      default: state_d = S_CLEAR;
    endcase

    if (accept) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      dec_cnt_d = trigger ? '0 : dec_cnt_q + DCW'(1);
    end

    // Samples arriving mid-clear and triggers that cannot start are both lost.
    if ((sin_valid && state_q == S_CLEAR) || (trigger && !start)) ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      wr_ptr_q  <= '0;
      clr_cnt_q <= '0;
      dec_cnt_q <= '0;
      tap_q     <= '0;
      base_q    <= '0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      clr_cnt_q <= clr_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      tap_q     <= tap_d;
      base_q    <= base_d;
      ovr_q     <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_CLEAR) mem[clr_cnt_q] <= '0;
      else if (accept)        mem[wr_ptr_q]  <= sin;
    end
  end

  // Sample read is registered so it lines up with the 1-clk coefficient ROM.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_din_q   <= '0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
    end else begin
      mac_first_q <= in_run && (tap_q == '0);
      mac_last_q  <= last_tap;
      if (in_run) mac_din_q <= mem[rd_addr];
    end
  end

  assign coef_addr = tap_q;
  assign mac_cin   = coef_data;
  assign mac_din   = mac_din_q;
  assign mac_first = mac_first_q;
  assign mac_last  = mac_last_q;
  assign busy      = (state_q != S_IDLE);
  assign ovr       = ovr_q;

endmodule
